// File: rtl/game_ctrl.sv
// game_ctrl -- controller for a timed "press the shown digit" keyboard game.
//
// A round starts from IDLE on Enter. While a round is playing, a target digit
// 1..8 is shown. Each correct key press adds one to a 2-digit BCD score and
// draws a new target from a free-running LFSR. A seconds timer counts down from
// GAME_SECONDS, and when it reaches zero the round ends in RESULT. Enter then
// returns the controller to IDLE.
//
// Parameters:
//   TICK_CYCLES  clk cycles per game-timer second
//   GAME_SECONDS round length in seconds (1..99)
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   key_valid    one-cycle strobe: a key changed state
//   last_change  scan code of the key that changed
//   key_down     per-key pressed flags
//   state        0=IDLE 1=PLAY 2=PAUSE 3=RESULT
//   nums         four display nibbles, MSN leftmost, 4'hA = dash
//   target       current target digit 1..8, 0 outside a round
//   round_done   one-cycle pulse when a round times out
//
// Optional build macro GAME_CTRL_PAUSE_EN enables a PAUSE state. Esc toggles
// between PLAY and PAUSE, and while paused the timer, score and target are
// frozen. When the macro is undefined, Esc is ignored.
module game_ctrl #(
  parameter int TICK_CYCLES  = 100_000_000,
  parameter int GAME_SECONDS = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  output logic [3:0]   state,
  output logic [15:0]  nums,
  output logic [3:0]   target,
  output logic         round_done
);

  localparam int            TW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
  localparam logic [7:0]    TIMER_INIT = {4'(GAME_SECONDS / 10), 4'(GAME_SECONDS % 10)};
  localparam logic [8:0]    CODE_ENTER = 9'h05A;
  localparam logic [8:0]    CODE_ESC   = 9'h076;

  // Entry gi holds the scan code for digit gi+1.
  localparam logic [7:0][8:0] DIGIT_CODES = {
    9'h03E, 9'h03D, 9'h036, 9'h02E, 9'h025, 9'h026, 9'h01E, 9'h016
  };

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_PLAY   = 4'd1,
`ifdef GAME_CTRL_PAUSE_EN
    ST_PAUSE  = 4'd2,
`endif
    ST_RESULT = 4'd3
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    timer_q, timer_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    target_q, target_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic          round_done_q, round_done_d;
  logic [15:0]   nums_q, nums_d;

  // ---------------------------------------------------------------- key decode
  logic       press;
  logic       is_enter;
  logic [7:0] digit_hit;
  logic [3:0] digit;      // 0 when the code is not a game digit
  logic [3:0] new_target;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
      assign digit_hit[gi] = (last_change == DIGIT_CODES[gi]);
    end
  endgenerate

  // Only press events count; a key_valid strobe for a released key is ignored.
  assign press      = key_valid && key_down[last_change];
  assign is_enter   = press && (last_change == CODE_ENTER);
  assign new_target = {1'b0, lfsr_q[2:0]} + 4'd1;

`ifdef GAME_CTRL_PAUSE_EN
  logic is_esc;
  assign is_esc = press && (last_change == CODE_ESC);
`endif

  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (digit_hit[i]) digit = 4'(i + 1);
    end
  end

  // ------------------------------------------------------------- BCD helpers
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    if (v == 8'h99) return v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // -------------------------------------------------------- next-state logic
  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    timer_d      = timer_q;
    tick_d       = tick_q;
    target_d     = target_q;
    round_done_d = 1'b0;
    // Fibonacci LFSR, taps 8,6,5,4. It runs every cycle, so a new target
    // depends on when the player acts.
    lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    case (state_q)
      ST_IDLE: begin
        if (is_enter) begin
          state_d  = ST_PLAY;
          score_d  = 8'h00;
          timer_d  = TIMER_INIT;
          tick_d   = '0;
          target_d = new_target;
        end
      end

      ST_PLAY: begin
        if (press && (digit != 4'd0) && (digit == target_q)) begin
          score_d  = bcd_inc_sat(score_q);
          target_d = new_target;
        end
        // The hit above is applied first, so a press that lands on the final
        // tick is still counted in the result.
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          timer_d = bcd_dec(timer_q);
          if (timer_q == 8'h01) begin
            state_d      = ST_RESULT;
            target_d     = 4'd0;
            round_done_d = 1'b1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
`ifdef GAME_CTRL_PAUSE_EN
        // If the round ends in this cycle, the end of round takes priority
        // over Esc.
        if (is_esc && (state_d == ST_PLAY)) state_d = ST_PAUSE;
`endif
      end

`ifdef GAME_CTRL_PAUSE_EN
      ST_PAUSE: begin
        if (is_esc) state_d = ST_PLAY;
      end
`endif

      ST_RESULT: begin
        if (is_enter) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // The display word is built from next-state values so that it stays
    // aligned with state and the score/timer registers.
    case (state_d)
      ST_IDLE:   nums_d = 16'hAAAA;
      ST_RESULT: nums_d = {8'hAA, score_d};
      default:   nums_d = {timer_d, score_d};
    endcase
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      score_q      <= 8'h00;
      timer_q      <= 8'h00;
      tick_q       <= '0;
      target_q     <= 4'd0;
      lfsr_q       <= 8'hA5;
      round_done_q <= 1'b0;
      nums_q       <= 16'hAAAA;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      timer_q      <= timer_d;
      tick_q       <= tick_d;
      target_q     <= target_d;
      lfsr_q       <= lfsr_d;
      round_done_q <= round_done_d;
      nums_q       <= nums_d;
    end
  end

  assign state      = state_q;
  assign nums       = nums_q;
  assign target     = target_q;
  assign round_done = round_done_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl -- self-checking bench for game_ctrl.
// The main instance uses TICK_CYCLES=4 and GAME_SECONDS=3. A second instance,
// with a 99-second round, is used for the score-saturation case.
// The reference model tracks the game as integers: state, score, seconds,
// tick and target. It is stepped once per clock edge.
module tb_game_ctrl;

  localparam int TC  = 4;
  localparam int GS  = 3;
  localparam int TC2 = 2;
  localparam int GS2 = 99;

  localparam logic [8:0] K_ENTER = 9'h05A;
  localparam logic [8:0] K_ESC   = 9'h076;
  localparam logic [8:0] K_OTHER = 9'h01C;
  localparam logic [8:0] DCODE [0:7] = '{9'h016, 9'h01E, 9'h026, 9'h025,
                                         9'h02E, 9'h036, 9'h03D, 9'h03E};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, kv, rst2, kv2;
  logic [8:0]   lc, lc2;
  logic [511:0] kd, kd2;
  logic [3:0]   st, tgt, st2, tgt2;
  logic [15:0]  nums, nums2;
  logic         rd, rd2;

  game_ctrl #(.TICK_CYCLES(TC), .GAME_SECONDS(GS)) dut (
    .clk(clk), .rst(rst), .key_valid(kv), .last_change(lc), .key_down(kd),
    .state(st), .nums(nums), .target(tgt), .round_done(rd)
  );

  game_ctrl #(.TICK_CYCLES(TC2), .GAME_SECONDS(GS2)) dut_sat (
    .clk(clk), .rst(rst2), .key_valid(kv2), .last_change(lc2), .key_down(kd2),
    .state(st2), .nums(nums2), .target(tgt2), .round_done(rd2)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         st;
    int         score;
    int         timer;
    int         tick;
    int         target;
    logic [7:0] lfsr;
    bit         rd;
  } mdl_t;

  mdl_t m, m2;

  typedef struct {
    bit          kv;
    logic [8:0]  code;
    bit          down;
    int          st;
    logic [15:0] nums;
    bit          rd;
  } vec_t;

  vec_t tbl [0:17];

  // ---------------------------------------------------------- reference model
  function automatic mdl_t step(mdl_t cur, int tc, int gs, bit r, bit k,
                                logic [8:0] c, bit down);
    mdl_t n;
    bit   pr;
    int   dig;
    n     = cur;
    pr    = k && down;
    dig   = 0;
    for (int i = 0; i < 8; i++) if (c == DCODE[i]) dig = i + 1;
    n.rd   = 1'b0;
    n.lfsr = {cur.lfsr[6:0], cur.lfsr[7] ^ cur.lfsr[5] ^ cur.lfsr[4] ^ cur.lfsr[3]};
    if (r) begin
      n = '{0, 0, 0, 0, 0, 8'hA5, 1'b0};
      return n;
    end
    case (cur.st)
      0: if (pr && c == K_ENTER) begin
           n.st = 1; n.score = 0; n.timer = gs; n.tick = 0;
           n.target = int'(cur.lfsr % 8) + 1;
         end
      1: begin
           if (pr && dig != 0 && dig == cur.target) begin
             n.score  = (cur.score < 99) ? cur.score + 1 : 99;
             n.target = int'(cur.lfsr % 8) + 1;
           end
           n.tick = cur.tick + 1;
           if (n.tick == tc) begin
             n.tick  = 0;
             n.timer = cur.timer - 1;
             if (n.timer == 0) begin
               n.st = 3; n.target = 0; n.rd = 1'b1;
             end
           end
`ifdef GAME_CTRL_PAUSE_EN
           if (n.st == 1 && pr && c == K_ESC) n.st = 2;
`endif
         end
      2: if (pr && c == K_ESC) n.st = 1;
      3: if (pr && c == K_ENTER) n.st = 0;
      default: n.st = 0;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] bcd(int x);
    return 8'((x / 10) * 16 + (x % 10));
  endfunction

  function automatic logic [15:0] exp_nums(mdl_t x);
    if (x.st == 0) return 16'hAAAA;
    if (x.st == 3) return {8'hAA, bcd(x.score)};
    return {bcd(x.timer), bcd(x.score)};
  endfunction

  // ---------------------------------------------------------------- checking
  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock transaction on the main instance, checked against the model.
  task automatic cyc(bit r, bit k, logic [8:0] c, bit down);
    rst = r; kv = k; lc = c;
    for (int w = 0; w < 16; w++) kd[w*32 +: 32] = $urandom;
    kd[c] = down;
    @(posedge clk);
    m = step(m, TC, GS, r, k, c, down);
    #1;
    $display("txn rst=%0b kv=%0b code=%h down=%0b -> state=%0d nums=%h target=%0d rd=%0b",
             r, k, c, down, st, nums, tgt, rd);
    chk("state",      16'(st),  16'(m.st));
    chk("nums",       nums,     exp_nums(m));
    chk("target",     16'(tgt), 16'(m.target));
    chk("round_done", 16'(rd),  16'(m.rd));
  endtask

  task automatic cyc2(bit r, bit k, logic [8:0] c, bit down);
    rst2 = r; kv2 = k; lc2 = c;
    for (int w = 0; w < 16; w++) kd2[w*32 +: 32] = $urandom;
    kd2[c] = down;
    @(posedge clk);
    m2 = step(m2, TC2, GS2, r, k, c, down);
    #1;
    $display("sat rst=%0b kv=%0b code=%h -> state=%0d nums=%h target=%0d",
             r, k, c, st2, nums2, tgt2);
    chk("sat_state",  16'(st2),  16'(m2.st));
    chk("sat_nums",   nums2,     exp_nums(m2));
    chk("sat_target", 16'(tgt2), 16'(m2.target));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 9'h000, 1'b0);
  endtask

  task automatic run_to_result();
    for (int i = 0; i < 40 && m.st != 3; i++) cyc(1'b0, 1'b0, 9'h000, 1'b0);
    chk("round_end_reached", 16'(st), 16'd3);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int         ev;
    logic [8:0] code;
    logic [3:0] saved_tgt;

    rst = 1'b1; kv = 1'b0; lc = '0; kd = '0;
    rst2 = 1'b1; kv2 = 1'b0; lc2 = '0; kd2 = '0;
    m  = '{0, 0, 0, 0, 0, 8'hA5, 1'b0};
    m2 = m;

    tbl[0]  = '{1'b1, K_ENTER, 1'b1, 1, 16'h0300, 1'b0};
    tbl[1]  = '{1'b1, K_ENTER, 1'b0, 1, 16'h0300, 1'b0};
    tbl[2]  = '{1'b1, K_ENTER, 1'b1, 1, 16'h0300, 1'b0};
    tbl[3]  = '{1'b0, 9'h000,  1'b0, 1, 16'h0300, 1'b0};
    tbl[4]  = '{1'b0, 9'h000,  1'b0, 1, 16'h0200, 1'b0};
    tbl[5]  = '{1'b1, K_OTHER, 1'b1, 1, 16'h0200, 1'b0};
    tbl[6]  = '{1'b0, 9'h000,  1'b0, 1, 16'h0200, 1'b0};
    tbl[7]  = '{1'b0, 9'h000,  1'b0, 1, 16'h0200, 1'b0};
    tbl[8]  = '{1'b0, 9'h000,  1'b0, 1, 16'h0100, 1'b0};
    tbl[9]  = '{1'b0, 9'h000,  1'b0, 1, 16'h0100, 1'b0};
    tbl[10] = '{1'b0, 9'h000,  1'b0, 1, 16'h0100, 1'b0};
    tbl[11] = '{1'b0, 9'h000,  1'b0, 1, 16'h0100, 1'b0};
    tbl[12] = '{1'b0, 9'h000,  1'b0, 3, 16'hAA00, 1'b1};
    tbl[13] = '{1'b1, 9'h016,  1'b1, 3, 16'hAA00, 1'b0};
    tbl[14] = '{1'b1, K_ESC,   1'b1, 3, 16'hAA00, 1'b0};
    tbl[15] = '{1'b1, K_ENTER, 1'b1, 0, 16'hAAAA, 1'b0};
    tbl[16] = '{1'b1, 9'h016,  1'b1, 0, 16'hAAAA, 1'b0};
    tbl[17] = '{1'b1, K_ESC,   1'b1, 0, 16'hAAAA, 1'b0};

    // Reset state
    cyc(1'b1, 1'b0, 9'h000, 1'b0);
    chk("rst_state",  16'(st),  16'd0);
    chk("rst_nums",   nums,     16'hAAAA);
    chk("rst_target", 16'(tgt), 16'd0);
    chk("rst_rd",     16'(rd),  16'd0);

    // Round with no hits: timing, display formats, ignored keys
    for (int i = 0; i < 18; i++) begin
      cyc(1'b0, tbl[i].kv, tbl[i].code, tbl[i].down);
      chk($sformatf("tbl%0d_state", i), 16'(st), 16'(tbl[i].st));
      chk($sformatf("tbl%0d_nums", i),  nums,     tbl[i].nums);
      chk($sformatf("tbl%0d_rd", i),    16'(rd),  16'(tbl[i].rd));
    end

    // Correct hit, then a release of the target key, then a wrong digit
    cyc(1'b0, 1'b1, K_ENTER, 1'b1);
    cyc(1'b0, 1'b1, DCODE[m.target-1], 1'b1);
    chk("hit_ones", 16'(nums[3:0]), 16'd1);
    total++;
    if (tgt < 4'd1 || tgt > 4'd8) begin
      bad++;
      $display("FAIL hit_target_range: got %0d want 1..8", tgt);
    end
    saved_tgt = 4'(m.target);
    cyc(1'b0, 1'b1, DCODE[saved_tgt-1], 1'b0);
    chk("release_score", 16'(nums[7:0]), 16'h0001);
    cyc(1'b0, 1'b1, DCODE[saved_tgt % 8], 1'b1);
    chk("wrong_score",  16'(nums[7:0]), 16'h0001);
    chk("wrong_target", 16'(tgt), 16'(saved_tgt));
    run_to_result();
    cyc(1'b0, 1'b1, K_ENTER, 1'b1);

    // Hit on the very tick that ends the round
    cyc(1'b0, 1'b1, K_ENTER, 1'b1);
    idle(11);
    cyc(1'b0, 1'b1, DCODE[m.target-1], 1'b1);
    chk("last_tick_state",  16'(st),  16'd3);
    chk("last_tick_nums",   nums,     16'hAA01);
    chk("last_tick_rd",     16'(rd),  16'd1);
    chk("last_tick_target", 16'(tgt), 16'd0);
    cyc(1'b0, 1'b1, K_ENTER, 1'b1);

    // Esc handling
    cyc(1'b0, 1'b1, K_ENTER, 1'b1);
    idle(2);
    cyc(1'b0, 1'b1, K_ESC, 1'b1);
`ifdef GAME_CTRL_PAUSE_EN
    chk("pause_state", 16'(st), 16'd2);
    idle(10);
    cyc(1'b0, 1'b1, DCODE[m.target-1], 1'b1);
    idle(9);
    chk("pause_state_held", 16'(st), 16'd2);
    chk("pause_nums_held",  nums,    16'h0300);
    cyc(1'b0, 1'b1, K_ESC, 1'b1);
    chk("resume_state", 16'(st), 16'd1);
`else
    chk("esc_ignored_state", 16'(st), 16'd1);
    chk("esc_ignored_nums",  nums,    16'h0300);
`endif
    run_to_result();
    cyc(1'b0, 1'b1, K_ENTER, 1'b1);

    // Reset in the middle of a round
    cyc(1'b0, 1'b1, K_ENTER, 1'b1);
    idle(3);
    cyc(1'b1, 1'b0, 9'h000, 1'b0);
    chk("midrst_state",  16'(st),  16'd0);
    chk("midrst_nums",   nums,     16'hAAAA);
    chk("midrst_target", 16'(tgt), 16'd0);
    chk("midrst_rd",     16'(rd),  16'd0);
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 1'b0, 9'h000, 1'b0);
      chk("midrst_no_pulse", 16'(rd), 16'd0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      ev = int'($urandom_range(0, 9));
      case (ev)
        0, 1, 2: code = (m.target > 0) ? DCODE[m.target-1] : DCODE[$urandom_range(0, 7)];
        3:       code = DCODE[$urandom_range(0, 7)];
        4:       code = K_ENTER;
        5:       code = K_ESC;
        6:       code = 9'($urandom_range(0, 511));
        default: code = 9'h000;
      endcase
      cyc(($urandom_range(0, 199) == 0), (ev < 8), code, ($urandom_range(0, 4) != 0));
    end

    // Score saturation on the long-round instance
    cyc2(1'b1, 1'b0, 9'h000, 1'b0);
    cyc2(1'b0, 1'b1, K_ENTER, 1'b1);
    for (int i = 0; i < 110; i++) cyc2(1'b0, 1'b1, DCODE[m2.target-1], 1'b1);
    chk("sat_score", 16'(nums2[7:0]), 16'h0099);
    chk("sat_playing", 16'(st2), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 100_000_000: clk cycles per game-timer second.
REQ-002 SHALL have parameter GAME_SECONDS, default 30: round length in seconds, range 1..99.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port key_valid, input, 1 bit: one-cycle strobe from the keyboard decoder that a key changed state.
REQ-006 SHALL have port last_change, input, 9 bits: code of the key that changed.
REQ-007 SHALL have port key_down, input, 512 bits: per-key pressed flags from the keyboard decoder.
REQ-008 SHALL have port state, output, 4 bits: game state; drives the VGA address generator and the segment logic.
REQ-009 SHALL have port nums, output, 16 bits: four display nibbles, MSN leftmost; 4'hA means dash.
REQ-010 SHALL have port target, output, 4 bits: current target digit, 1..8, or 0 when no round is active.
REQ-011 SHALL have port round_done, output, 1 bit: one-cycle pulse when a round ends.

Function
REQ-012 SHALL treat a cycle as a press event only when key_valid=1 and key_down[last_change]=1; release events are ignored.
REQ-013 SHALL map digit codes 9'h016, 01E, 026, 025, 02E, 036, 03D, 03E to digits 1..8, Enter to 9'h05A and Esc to 9'h076; any other code is ignored.
REQ-014 SHALL implement the states IDLE=0, PLAY=1, PAUSE=2 and RESULT=3 on the state output.
REQ-015 In IDLE, an Enter press SHALL move to PLAY, clear score, load the timer with GAME_SECONDS, clear the tick counter, and load target.
REQ-016 SHALL run an 8-bit Fibonacci LFSR, taps 8,6,5,4, every cycle; a target load SHALL set target = lfsr[2:0]+1.
REQ-017 In PLAY, a press event whose digit equals target SHALL increment the 2-digit BCD score and reload target from the LFSR, both visible the next cycle.
REQ-018 In PLAY, a press event with a wrong digit SHALL leave score and target unchanged.
REQ-019 Score SHALL saturate at 99.
REQ-020 In PLAY only, the tick counter SHALL count 0..TICK_CYCLES-1; at wrap, the BCD timer SHALL decrement by one.
REQ-021 When the timer decrements from 1 to 0, SHALL enter RESULT, set target=0, and pulse round_done for exactly one cycle.
REQ-022 If a tick that ends the round and a correct press occur in the same cycle, SHALL count the hit first and then enter RESULT.
REQ-023 In RESULT, an Enter press SHALL go to IDLE; the score SHALL be held until the next round starts.
REQ-024 nums SHALL read: IDLE 16'hAAAA; PLAY and PAUSE {timer_bcd, score_bcd}; RESULT {8'hAA, score_bcd}.
REQ-025 Outputs SHALL be registered.
REQ-026 Enter pressed in PLAY or PAUSE SHALL be ignored.

Reset
REQ-027 On rst=1 at a clk edge, SHALL set state=IDLE, nums=16'hAAAA, target=0, round_done=0, score=0, timer=0, tick counter=0, and LFSR=8'hA5.
REQ-028 Reset mid-round SHALL abort the round without pulsing round_done.

Configuration
REQ-029 With macro GAME_CTRL_PAUSE_EN defined, Esc in PLAY SHALL go to PAUSE, freezing the tick counter, timer, score and target.
REQ-030 With GAME_CTRL_PAUSE_EN defined, Esc in PAUSE SHALL return to PLAY, and digit presses in PAUSE SHALL be ignored.
REQ-031 Without GAME_CTRL_PAUSE_EN, the PAUSE state SHALL not exist and Esc SHALL be ignored in every state.

Verification
REQ-032 TICK_CYCLES=4, GAME_SECONDS=3; reset, Enter, no keys -> state=1, nums=16'h0300; after 12 PLAY cycles state=3, nums=16'hAA00, round_done high 1 cycle.
REQ-033 In PLAY, press the digit equal to target -> next cycle score ones digit=1 and target reloaded within 1..8; a wrong digit leaves nums unchanged.
REQ-034 A key_valid event with key_down bit=0 (release of the target digit) -> no score change.
REQ-035 Force score=99 and press the correct digit -> score stays 99.
REQ-036 With GAME_CTRL_PAUSE_EN: Esc in PLAY, wait 20 cycles -> state=2 and timer unchanged; Esc again -> state=1; without the macro, Esc -> state stays 1.
REQ-037 Assert rst mid-PLAY -> next cycle state=0, nums=16'hAAAA, target=0, and no round_done pulse.
